// File: rtl/adc_sample_deserializer_pkg.sv
// rtl/adc_sample_deserializer_pkg.sv - shared FSM encodings and ADC offset constants
//
// Purpose: definitions shared by the ADC front end and the output adder's
// signed-to-offset-binary conversion, so both sides use one offset constant.
// Contents:
//   state_t            2-bit frame FSM encoding (IDLE, SETUP, SHIFT, DONE)
//   ADC_DATA_BITS      number of data bits in one ADC conversion
//   ADC_OFFSET         offset-binary midscale code
//   offset_to_twos()   offset-binary to two's complement of the same width
package adc_sample_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          ADC_DATA_BITS = 12;
    localparam logic [11:0] ADC_OFFSET    = 12'h800;

    // Subtracting the midscale code from an offset-binary word only flips
    // its MSB, so an XOR with the offset does the job without an adder.
    function automatic logic [11:0] offset_to_twos(input logic [11:0] d);
        return d ^ ADC_OFFSET;
    endfunction

endpackage

// File: rtl/adc_sample_deserializer_sclk.sv
// rtl/adc_sample_deserializer_sclk.sv - SCLK generator for the serial ADC interface
//
// Purpose: sclk_divider. Produces the ADC serial clock by toggling every DIV
// clk cycles while enabled; parked high whenever disabled.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   run the divider (frame FSM in SHIFT)
//   sclk     out  registered serial clock, idles high
//   rise_en  out  sclk goes 0->1 on the coming clk edge
//   fall_en  out  sclk goes 1->0 on the coming clk edge
module sclk_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_en,
    output logic fall_en
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          toggle;

    assign toggle  = en && (cnt == LAST);
    assign rise_en = toggle && !sclk;
    assign fall_en = toggle && sclk;

    // The count restarts from zero on every enable so the first fall lands
    // exactly DIV cycles after the FSM enters SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (toggle) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_sample_deserializer.sv
// rtl/adc_sample_deserializer.sv - serial ADC reader delivering signed samples to the band filters
//
// Purpose: on each sample tick, clocks one 16-bit frame (4 leading zeros +
// 12 offset-binary data bits, MSB first) out of the ADC, converts the data to
// a signed W-bit sample and strobes it to the low/mid/high band filters.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset; aborts any frame
//   tick     in   sample-rate strobe, starts a conversion from IDLE
//   sdata    in   ADC serial data, launched on SCLK falling edge
//   sclk     out  ADC serial clock, idles high
//   cs_n     out  ADC chip select, active-low
//   x        out  signed sample, held between valid pulses
//   x_valid  out  one-cycle pulse when x is updated
//   overrun  out  sticky: tick seen while a frame was in progress
module adc_sample_deserializer
    import adc_sample_deserializer_pkg::*;
#(
    parameter int W     = 23,
    parameter int NBITS = 16,
    parameter int DIV   = 4,
    parameter int FRAC  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         sdata,
    output logic         sclk,
    output logic         cs_n,
    output logic [W-1:0] x,
    output logic         x_valid,
    output logic         overrun
);

    localparam int             BW         = $clog2(NBITS + 1);
    localparam int             SW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0]  BITS_LAST  = BW'(NBITS);
    localparam logic [SW-1:0]  SETUP_LAST = SW'(DIV - 1);

    state_t                   state;
    state_t                   next_state;
    logic [BW-1:0]            bit_cnt;
    logic [SW-1:0]            setup_cnt;
    logic [ADC_DATA_BITS-1:0] shreg;
    logic                     rise_en;
    logic                     fall_en;
    logic                     setup_done;
    logic                     last_rise;
    logic                     start;
    logic                     shift_active;
    logic                     capture;
    logic [ADC_DATA_BITS-1:0] d_twos;
    logic [W-1:0]             sample_w;

    sclk_divider #(
        .DIV (DIV)
    ) u_sclk_divider (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (shift_active),
        .sclk    (sclk),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    // bit_cnt counts bits launched by the ADC (SCLK falls); the frame ends
    // on the rise that samples the last launched bit.
    assign setup_done = (setup_cnt == SETUP_LAST);
    assign last_rise  = rise_en && (bit_cnt == BITS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick)       next_state = SETUP;
            SETUP:   if (setup_done) next_state = SHIFT;
            SHIFT:   if (last_rise)  next_state = DONE;
            DONE:                    next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    always_comb begin
        start        = 1'b0;
        shift_active = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE:    start        = tick;
            SHIFT:   shift_active = 1'b1;
            DONE:    capture      = 1'b1;
            default: ;
        endcase
    end

    // Only the low 12 bits are kept: the leading frame bits shift off the
    // top and are never looked at.
    assign d_twos   = offset_to_twos(shreg);
    assign sample_w = {{(W - ADC_DATA_BITS){d_twos[ADC_DATA_BITS-1]}}, d_twos} << FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cs_n      <= 1'b1;
            x         <= '0;
            x_valid   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            setup_cnt <= (state == SETUP && !setup_done) ? setup_cnt + 1'b1 : '0;

            if (start) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else begin
                if (fall_en) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (rise_en) begin
                    shreg <= {shreg[ADC_DATA_BITS-2:0], sdata};
                end
            end

            // Registered from next_state so chip select never glitches on
            // a state decode.
            cs_n    <= (next_state == IDLE);
            x_valid <= capture;
            if (capture) begin
                x <= sample_w;
            end

            // A tick in DONE is still part of the frame, so it is an overrun.
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
